// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder.
//   state_t   : decoder FSM state (start-up settle, then tracking)
//   PH_*      : 2-bit {A,B} phase states in forward Gray order 00 -> 10 -> 11 -> 01
//   DIR_*     : direction encoding shared with the up/down counters (0 = up, 1 = down)
//   gray_next : the phase state that follows a given one in the forward direction
package quad_pkg;

  typedef enum logic {
    StInit,
    StTrack
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic logic [1:0] gray_next(input logic [1:0] ph);
    logic [1:0] nxt;
    unique case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_filt.sv
// One phase of the decoder front end: 2-flop synchronizer followed by a stability
// filter. The filtered value only follows the synchronized input once it has differed
// from it for FILT_LEN consecutive cycles, so shorter pulses are dropped.
//   clk, rst : clock, asynchronous active-high reset
//   load     : force the filtered value to the synchronized input this cycle
//   d_in     : raw asynchronous phase input
//   f_out    : filtered phase; shows the value being loaded while load is high
module quad_filt #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic d_in,
  output logic f_out
);

  localparam logic [3:0] LastCnt = 4'(FILT_LEN - 1);

  logic       s1, s2, f;
  logic [3:0] c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      f  <= 1'b0;
      c  <= '0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
      if (load) begin
        f <= s2;
        c <= '0;
      end else if (s2 == f) begin
        c <= '0;
      end else if (c == LastCnt) begin
        f <= s2;
        c <= '0;
      end else begin
        c <= c + 4'd1;
      end
    end
  end

  // Bypass on load so the parent can capture the forced value in the same edge.
  assign f_out = load ? s2 : f;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature (A/B) x4 decoder. Filters both phases, waits for them to settle after
// reset, then turns each legal Gray transition into a one-cycle step pulse with a
// direction bit and keeps a wrapping position count. Two-bit jumps set a sticky error.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : decode enable (phases are still tracked while low)
//   clr        : synchronous clear of pos and err
//   a_in, b_in : asynchronous encoder phases
//   pos        : wrapping position count
//   step       : one-cycle pulse per valid transition
//   dir        : direction of the last step (0 = up, 1 = down)
//   err        : sticky illegal-transition flag
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a_in,
  input  logic             b_in,
  output logic [CNT_W-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam logic [4:0] InitLast = 5'(FILT_LEN + 1);

  state_t     state;
  logic [4:0] wait_cnt;
  logic [1:0] prev;
  logic [1:0] cur;
  logic       fa, fb;
  logic       load;
  logic       fwd, rev, bad;

  // Last INIT cycle: both filters snap to their synchronized inputs.
  assign load = (state == StInit) && (wait_cnt == InitLast);

  quad_filt #(
    .FILT_LEN(FILT_LEN)
  ) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d_in (a_in),
    .f_out(fa)
  );

  quad_filt #(
    .FILT_LEN(FILT_LEN)
  ) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d_in (b_in),
    .f_out(fb)
  );

  assign cur = {fa, fb};

  always_comb begin
    fwd = (cur == gray_next(prev));
    rev = (prev == gray_next(cur));
    bad = (cur == ~prev);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StInit;
      wait_cnt <= '0;
      prev     <= PH_00;
      pos      <= '0;
      step     <= 1'b0;
      dir      <= DIR_UP;
      err      <= 1'b0;
    end else begin
      step <= 1'b0;
      unique case (state)
        StInit: begin
          if (load) begin
            state    <= StTrack;
            prev     <= cur;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        StTrack: begin
          prev <= cur;
          if (en) begin
            if (fwd) begin
              step <= 1'b1;
              dir  <= DIR_UP;
              pos  <= pos + CNT_W'(1);
            end else if (rev) begin
              step <= 1'b1;
              dir  <= DIR_DN;
              pos  <= pos - CNT_W'(1);
            end else if (bad) begin
              err <= 1'b1;
            end
          end
        end
        default: state <= StInit;
      endcase
      // Clear wins over a same-cycle count or error; step/dir still report the decode.
      if (clr) begin
        pos <= '0;
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

  localparam int unsigned CntW    = 16;
  localparam int unsigned FiltLen = 3;
  localparam int          Lat     = 3 + FiltLen;

  logic            clk = 1'b0;
  logic            rst, en, clr, a_in, b_in;
  logic [CntW-1:0] pos;
  logic            step, dir, err;

  int checks = 0;
  int errors = 0;

  logic [CntW-1:0] pos_m;
  logic            err_m;
  logic [1:0]      cur_lvl;

  quad_decoder #(
    .CNT_W   (CntW),
    .FILT_LEN(FiltLen)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr),
    .a_in(a_in),
    .b_in(b_in),
    .pos (pos),
    .step(step),
    .dir (dir),
    .err (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Position of an {A,B} level around the forward cycle 00,10,11,01.
  function automatic int ph_idx(input logic [1:0] l);
    case (l)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Drive a level and watch `cycles` negedges for step pulses.
  task automatic run_level(input logic [1:0] lvl, input int cycles, output int ns,
                           output int first_at, output logic last_dir);
    a_in = lvl[1];
    b_in = lvl[0];
    ns = 0;
    first_at = -1;
    last_dir = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        ns++;
        if (first_at < 0) first_at = k;
        last_dir = dir;
      end
    end
  endtask

  task automatic move(input logic [1:0] lvl, input string tag);
    int   d, ns, fat, exp_ns;
    logic ld;
    d = (ph_idx(lvl) - ph_idx(cur_lvl) + 4) % 4;
    exp_ns = (en && (d == 1 || d == 3)) ? 1 : 0;
    if (en) begin
      if (d == 1) pos_m = pos_m + 1'b1;
      else if (d == 3) pos_m = pos_m - 1'b1;
      else if (d == 2) err_m = 1'b1;
    end
    cur_lvl = lvl;
    run_level(lvl, 10, ns, fat, ld);
    check($sformatf("%s.steps", tag), ns, exp_ns);
    if (exp_ns == 1) begin
      check($sformatf("%s.latency", tag), fat, Lat);
      check($sformatf("%s.dir", tag), {31'd0, ld}, (d == 3) ? 1 : 0);
    end
    check($sformatf("%s.pos", tag), {16'd0, pos}, {16'd0, pos_m});
    check($sformatf("%s.err", tag), {31'd0, err}, {31'd0, err_m});
  endtask

  task automatic clear_pulse(input string tag);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    pos_m = '0;
    err_m = 1'b0;
    check($sformatf("%s.pos", tag), {16'd0, pos}, 0);
    check($sformatf("%s.err", tag), {31'd0, err}, 0);
  endtask

  task automatic pulse_a(input int len, input int window, output int ns,
                         output logic d_first, output logic d_last);
    a_in = 1'b1;
    ns = 0;
    d_first = 1'b0;
    d_last = 1'b0;
    for (int k = 1; k <= len + window; k++) begin
      @(negedge clk);
      if (k == len) a_in = 1'b0;
      if (step === 1'b1) begin
        if (ns == 0) d_first = dir;
        d_last = dir;
        ns++;
      end
    end
  endtask

  initial begin
    int          ns, fat;
    logic        d1, d2;
    logic [1:0]  lvl;
    logic [1:0]  fwd_lvl;

    rst = 1'b1; en = 1'b1; clr = 1'b0; a_in = 1'b0; b_in = 1'b0;
    pos_m = '0; err_m = 1'b0; cur_lvl = 2'b00;
    repeat (3) @(negedge clk);
    check("reset.pos", {16'd0, pos}, 0);
    check("reset.step", {31'd0, step}, 0);
    check("reset.dir", {31'd0, dir}, 0);
    check("reset.err", {31'd0, err}, 0);
    rst = 1'b0;
    run_level(2'b00, 12, ns, fat, d1);
    check("init.steps", ns, 0);

    // Forward sweep
    move(2'b10, "fwd1");
    move(2'b11, "fwd2");
    move(2'b01, "fwd3");
    move(2'b00, "fwd4");
    check("fwd.pos4", {16'd0, pos}, 4);

    // Reverse sweep and wrap below zero
    clear_pulse("clr_before_rev");
    move(2'b01, "rev1");
    move(2'b11, "rev2");
    move(2'b10, "rev3");
    move(2'b00, "rev4");
    check("rev.pos_fffc", {16'd0, pos}, 32'h0000_fffc);

    // Glitches on A from 00
    pulse_a(2, 14, ns, d1, d2);
    check("glitch2.steps", ns, 0);
    check("glitch2.pos", {16'd0, pos}, {16'd0, pos_m});
    pulse_a(3, 14, ns, d1, d2);
    check("glitch3.steps", ns, 2);
    check("glitch3.dir_first", {31'd0, d1}, 0);
    check("glitch3.dir_last", {31'd0, d2}, 1);
    check("glitch3.pos", {16'd0, pos}, {16'd0, pos_m});

    // Illegal double change then clear
    move(2'b11, "illegal");
    clear_pulse("clr_after_err");

    // Disabled transitions are lost
    en = 1'b0;
    move(2'b01, "dis1");
    move(2'b00, "dis2");
    move(2'b10, "dis3");
    move(2'b11, "dis4");
    en = 1'b1;
    move(2'b01, "reen");

    // Clear coinciding with a step
    fwd_lvl = (cur_lvl == 2'b00) ? 2'b10 : (cur_lvl == 2'b10) ? 2'b11 :
              (cur_lvl == 2'b11) ? 2'b01 : 2'b00;
    a_in = fwd_lvl[1];
    b_in = fwd_lvl[0];
    cur_lvl = fwd_lvl;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 5) clr = 1'b1;
      if (k == 6) begin
        check("clr_step.step", {31'd0, step}, 1);
        check("clr_step.pos", {16'd0, pos}, 0);
        clr = 1'b0;
      end
    end
    pos_m = '0;
    err_m = 1'b0;

    // Randomized walk against the model
    for (int i = 0; i < 40; i++) begin
      lvl = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 3) != 0);
      move(lvl, $sformatf("rand%0d", i));
      if ($urandom_range(0, 9) == 0) clear_pulse($sformatf("rand_clr%0d", i));
    end
    en = 1'b1;

    // Reset mid-operation with phases parked at 11
    clear_pulse("pre_rst");
    fwd_lvl = (cur_lvl == 2'b00) ? 2'b01 : (cur_lvl == 2'b10) ? 2'b00 :
              (cur_lvl == 2'b11) ? 2'b10 : 2'b11;
    move(fwd_lvl, "pre_rst_rev");
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.pos", {16'd0, pos}, 0);
    check("midrst.step", {31'd0, step}, 0);
    check("midrst.dir", {31'd0, dir}, 0);
    check("midrst.err", {31'd0, err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pos_m = '0;
    err_m = 1'b0;
    cur_lvl = 2'b11;
    run_level(2'b11, 15, ns, fat, d1);
    check("pwrup11.steps", ns, 0);
    check("pwrup11.err", {31'd0, err}, 0);
    move(2'b01, "after_rst");
    check("after_rst.pos1", {16'd0, pos}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
